// File: rtl/btn_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btn_event_ctrl
// Purpose  : Per-button debounce FSMs on a shared sample tick, press/release
//            (optional auto-repeat) event flags, round-robin serialisation
//            onto one valid/ready event port. Optional: BTN_AUTOREPEAT_EN.
// Revision : 1.0
// ============================================================================
module btn_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_CNT   = 8,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic [1:0]               evt_type,
  output logic                     evt_drop
);

  localparam int IDW = $clog2(N_BTN);
  localparam int SW  = IDW + 1;
  localparam int TW  = $clog2(TICK_DIV);
  localparam int CW  = $clog2(STABLE_CNT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM_ON  = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_ARM_OFF = 2'd3;

  localparam logic [1:0] TYPE_PRESS   = 2'b00;
  localparam logic [1:0] TYPE_RELEASE = 2'b01;
  localparam logic [1:0] TYPE_REPEAT  = 2'b10;

  if (N_BTN < 2 || TICK_DIV < 2 || STABLE_CNT < 1 ||
      HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("btn_event_ctrl: illegal parameter set");
  end

  // ---------------------------------------------------------------- signals
  logic [N_BTN-1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
  logic                      tick;

  logic [N_BTN-1:0][1:0]     state_q, state_d;
  logic [N_BTN-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [N_BTN-1:0]          level_q, level_d;
  logic [N_BTN-1:0]          set_press, set_rel;

  logic [N_BTN-1:0]          pend_press_q, pend_press_d;
  logic [N_BTN-1:0]          pend_rel_q, pend_rel_d;
  logic [N_BTN-1:0]          pend_rep, pend_any;
  logic [N_BTN-1:0]          clr_press, clr_rel;

  logic                      req_found;
  logic [IDW-1:0]            req_idx;
  logic [1:0]                req_type;
  logic [SW-1:0]             scan;

  logic                      load;
  logic                      valid_q, valid_d;
  logic [IDW-1:0]            id_q, id_d;
  logic [1:0]                type_q, type_d;
  logic                      drop_q, drop_d;
  logic [IDW-1:0]            rr_q, rr_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);

  logic [N_BTN-1:0][HW-1:0]  hold_q, hold_d;
  logic [N_BTN-1:0]          rep_armed_q, rep_armed_d;
  logic [N_BTN-1:0]          set_rep, clr_rep;
  logic [N_BTN-1:0]          pend_rep_q, pend_rep_d;

  assign pend_rep = pend_rep_q;
`else
  assign pend_rep = '0;
`endif

  assign pend_any = pend_press_q | pend_rel_q | pend_rep;

  // ------------------------------------------------------ sync + timebase
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // ------------------------------------------------------ debounce FSMs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    set_press = '0;
    set_rel   = '0;
`ifdef BTN_AUTOREPEAT_EN
    hold_d      = hold_q;
    rep_armed_d = rep_armed_q;
    set_rep     = '0;
`endif
    if (tick) begin
      for (int i = 0; i < N_BTN; i++) begin
        case (state_q[i])
          ST_IDLE: begin
            if (sync2_q[i]) begin
              if (STABLE_CNT == 1) begin
                state_d[i]   = ST_PRESSED;
                level_d[i]   = 1'b1;
                set_press[i] = 1'b1;
                cnt_d[i]     = '0;
`ifdef BTN_AUTOREPEAT_EN
                hold_d[i]      = '0;
                rep_armed_d[i] = 1'b0;
`endif
              end else begin
                state_d[i] = ST_ARM_ON;
                cnt_d[i]   = CW'(1);
              end
            end
          end
          ST_ARM_ON: begin
            if (!sync2_q[i]) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] + CW'(1) == CW'(STABLE_CNT)) begin
              state_d[i]   = ST_PRESSED;
              level_d[i]   = 1'b1;
              set_press[i] = 1'b1;
              cnt_d[i]     = '0;
`ifdef BTN_AUTOREPEAT_EN
              hold_d[i]      = '0;
              rep_armed_d[i] = 1'b0;
`endif
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          ST_PRESSED: begin
            if (!sync2_q[i]) begin
              if (STABLE_CNT == 1) begin
                state_d[i] = ST_IDLE;
                level_d[i] = 1'b0;
                set_rel[i] = 1'b1;
                cnt_d[i]   = '0;
              end else begin
                state_d[i] = ST_ARM_OFF;
                cnt_d[i]   = CW'(1);
              end
            end
`ifdef BTN_AUTOREPEAT_EN
            // Hold counter only advances while firmly pressed; first period is
            // HOLD_TICKS, every later one REPEAT_TICKS.
            else if (hold_q[i] + HW'(1) ==
                     (rep_armed_q[i] ? HW'(REPEAT_TICKS) : HW'(HOLD_TICKS))) begin
              set_rep[i]     = 1'b1;
              hold_d[i]      = '0;
              rep_armed_d[i] = 1'b1;
            end else begin
              hold_d[i] = hold_q[i] + HW'(1);
            end
`endif
          end
          ST_ARM_OFF: begin
            if (sync2_q[i]) begin
              state_d[i] = ST_PRESSED;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] + CW'(1) == CW'(STABLE_CNT)) begin
              state_d[i] = ST_IDLE;
              level_d[i] = 1'b0;
              set_rel[i] = 1'b1;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // ------------------------------------------------------ round-robin pick
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    scan      = '0;
    for (int k = 0; k < N_BTN; k++) begin
      scan = {1'b0, rr_q} + SW'(k);
      if (scan >= SW'(N_BTN)) scan = scan - SW'(N_BTN);
      if (!req_found && pend_any[scan[IDW-1:0]]) begin
        req_found = 1'b1;
        req_idx   = scan[IDW-1:0];
      end
    end
    if (pend_press_q[req_idx])  req_type = TYPE_PRESS;
    else if (pend_rep[req_idx]) req_type = TYPE_REPEAT;
    else                        req_type = TYPE_RELEASE;
  end

  // ------------------------------------------------------ output register
  always_comb begin
    load      = !valid_q || evt_ready;
    valid_d   = valid_q;
    id_d      = id_q;
    type_d    = type_q;
    rr_d      = rr_q;
    clr_press = '0;
    clr_rel   = '0;
`ifdef BTN_AUTOREPEAT_EN
    clr_rep   = '0;
`endif
    if (load) begin
      valid_d = req_found;
      if (req_found) begin
        id_d   = req_idx;
        type_d = req_type;
        if (req_type == TYPE_PRESS)        clr_press[req_idx] = 1'b1;
        else if (req_type == TYPE_RELEASE) clr_rel[req_idx]   = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
        else                               clr_rep[req_idx]   = 1'b1;
`endif
        rr_d = (req_idx == IDW'(N_BTN - 1)) ? '0 : req_idx + IDW'(1);
      end
    end

    // A set landing on the clock its flag is consumed is a fresh event, not a loss.
    pend_press_d = (pend_press_q & ~clr_press) | set_press;
    pend_rel_d   = (pend_rel_q & ~clr_rel) | set_rel;
    drop_d       = |(set_press & pend_press_q & ~clr_press) |
                   |(set_rel & pend_rel_q & ~clr_rel);
`ifdef BTN_AUTOREPEAT_EN
    pend_rep_d   = (pend_rep_q & ~clr_rep) | set_rep;
    drop_d       = drop_d | (|(set_rep & pend_rep_q & ~clr_rep));
`endif
  end

  // ------------------------------------------------------ state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      tick_cnt_q   <= '0;
      state_q      <= {N_BTN{ST_IDLE}};
      cnt_q        <= '0;
      level_q      <= '0;
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      valid_q      <= 1'b0;
      id_q         <= '0;
      type_q       <= '0;
      drop_q       <= 1'b0;
      rr_q         <= '0;
`ifdef BTN_AUTOREPEAT_EN
      hold_q       <= '0;
      rep_armed_q  <= '0;
      pend_rep_q   <= '0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      valid_q      <= valid_d;
      id_q         <= id_d;
      type_q       <= type_d;
      drop_q       <= drop_d;
      rr_q         <= rr_d;
`ifdef BTN_AUTOREPEAT_EN
      hold_q       <= hold_d;
      rep_armed_q  <= rep_armed_d;
      pend_rep_q   <= pend_rep_d;
`endif
    end
  end

  assign btn_level = level_q;
  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign evt_type  = type_q;
  assign evt_drop  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_event_ctrl
// Purpose  : Directed bench for btn_event_ctrl with an event scoreboard.
// Revision : 1.0
// ============================================================================
module tb_btn_event_ctrl;

  localparam int N_BTN        = 4;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_CNT   = 3;
  localparam int HOLD_TICKS   = 5;
  localparam int REPEAT_TICKS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = '0;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic       evt_drop;

  btn_event_ctrl #(
    .N_BTN(N_BTN), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT),
    .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_type(evt_type), .evt_drop(evt_drop)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_accepts = 0;
  int         n_valid_cyc = 0;
  int         n_drops = 0;
  logic [3:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Event consumer: every accepted event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid) n_valid_cyc++;
      if (evt_drop)  n_drops++;
      if (evt_valid && evt_ready) begin
        n_accepts++;
        if (sb.size() == 0) begin
          check("evt_unexpected", {28'd0, evt_id, evt_type}, 32'hFFFF_FFFF);
        end else begin
          check("evt_id_type", {28'd0, evt_id, evt_type}, {28'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_level(input int b, input logic v, output int cyc);
    cyc = 0;
    while (btn_level[b] !== v && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("level_wait", {31'd0, btn_level[b]}, {31'd0, v});
  endtask

  int cyc, vc0, a0, d0;

  initial begin
    // Reset with raw inputs toggling
    for (int i = 0; i < 6; i++) begin
      btn_raw = 4'($urandom);
      step(1);
    end
    check("rst_level", {28'd0, btn_level}, 32'd0);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_id",    {30'd0, evt_id}, 32'd0);
    check("rst_type",  {30'd0, evt_type}, 32'd0);
    check("rst_drop",  {31'd0, evt_drop}, 32'd0);
    btn_raw = '0;
    rst_n   = 1'b1;
    step(200);
    check("idle_level",   {28'd0, btn_level}, 32'd0);
    check("idle_valid_n", n_valid_cyc, 0);

    // Single press and release on button 2
    evt_ready = 1'b1;
    vc0 = n_valid_cyc;
    sb.push_back({2'd2, 2'b00});
    btn_raw[2] = 1'b1;
    wait_level(2, 1'b1, cyc);
    check("press_delay_window", {31'd0, (cyc >= 11 && cyc <= 14)}, 32'd1);
    step(1);
    check("press_latency", {29'd0, evt_valid, evt_id, evt_type}, {29'd0, 1'b1, 2'd2, 2'b00});
    step(6);
    check("press_valid_1clk", n_valid_cyc - vc0, 1);
    check("press_sb_empty", sb.size(), 0);
    sb.push_back({2'd2, 2'b01});
    btn_raw[2] = 1'b0;
    wait_level(2, 1'b0, cyc);
    step(6);
    check("release_sb_empty", sb.size(), 0);

    // Glitch on button 0: high for exactly two ticks
    a0 = n_accepts;
    d0 = n_drops;
    btn_raw[0] = 1'b1;
    step(8);
    btn_raw[0] = 1'b0;
    step(40);
    check("glitch_level", {31'd0, btn_level[0]}, 32'd0);
    check("glitch_no_evt", n_accepts - a0, 0);
    check("glitch_no_drop", n_drops - d0, 0);

    // Mid-operation reset discards a stalled event
    evt_ready  = 1'b0;
    btn_raw[2] = 1'b1;
    wait_level(2, 1'b1, cyc);
    step(3);
    check("inflight_valid", {31'd0, evt_valid}, 32'd1);
    rst_n   = 1'b0;
    btn_raw = '0;
    step(2);
    check("midrst_valid", {31'd0, evt_valid}, 32'd0);
    check("midrst_level", {28'd0, btn_level}, 32'd0);
    rst_n = 1'b1;
    step(40);
    check("postrst_valid", {31'd0, evt_valid}, 32'd0);

    // Simultaneous presses on 0,1,3 under a 60-clk stall
    sb.push_back({2'd0, 2'b00});
    sb.push_back({2'd1, 2'b00});
    sb.push_back({2'd3, 2'b00});
    btn_raw = 4'b1011;
    wait_level(0, 1'b1, cyc);
    step(2);
    check("stall_start", {29'd0, evt_valid, evt_id, evt_type}, {29'd0, 1'b1, 2'd0, 2'b00});
    step(60);
    check("stall_end", {29'd0, evt_valid, evt_id, evt_type}, {29'd0, 1'b1, 2'd0, 2'b00});
    evt_ready = 1'b1;
    step(1);
    check("b2b_id1", {29'd0, evt_valid, evt_id, evt_type}, {29'd0, 1'b1, 2'd1, 2'b00});
    step(1);
    check("b2b_id3", {29'd0, evt_valid, evt_id, evt_type}, {29'd0, 1'b1, 2'd3, 2'b00});
    step(1);
    check("b2b_done", {31'd0, evt_valid}, 32'd0);
    sb.push_back({2'd0, 2'b01});
    sb.push_back({2'd1, 2'b01});
    sb.push_back({2'd3, 2'b01});
    btn_raw = '0;
    wait_level(0, 1'b0, cyc);
    step(8);
    check("multi_rel_sb_empty", sb.size(), 0);
    // Pointer has wrapped to 0: button 0 wins over button 1
    sb.push_back({2'd0, 2'b00});
    sb.push_back({2'd1, 2'b00});
    btn_raw = 4'b0011;
    wait_level(0, 1'b1, cyc);
    step(1);
    check("wrap_first", {29'd0, evt_valid, evt_id, evt_type}, {29'd0, 1'b1, 2'd0, 2'b00});
    step(1);
    check("wrap_second", {29'd0, evt_valid, evt_id, evt_type}, {29'd0, 1'b1, 2'd1, 2'b00});
    step(4);
    sb.push_back({2'd0, 2'b01});
    sb.push_back({2'd1, 2'b01});
    btn_raw = '0;
    wait_level(0, 1'b0, cyc);
    step(8);
    check("wrap_sb_empty", sb.size(), 0);

    // Overflow: btn1 press/release/press while output blocked by btn3
    d0 = n_drops;
    evt_ready = 1'b0;
    sb.push_back({2'd3, 2'b00});
    btn_raw[3] = 1'b1;
    wait_level(3, 1'b1, cyc);
    step(2);
    check("block_id3", {29'd0, evt_valid, evt_id, evt_type}, {29'd0, 1'b1, 2'd3, 2'b00});
    sb.push_back({2'd1, 2'b00});
    btn_raw[1] = 1'b1;
    wait_level(1, 1'b1, cyc);
    check("drop_none_yet", n_drops - d0, 0);
    sb.push_back({2'd1, 2'b01});
    btn_raw[1] = 1'b0;
    wait_level(1, 1'b0, cyc);
    btn_raw[1] = 1'b1;
    wait_level(1, 1'b1, cyc);
    step(2);
    check("drop_once", n_drops - d0, 1);
    step(5);
    evt_ready = 1'b1;
    step(1);
    check("ovf_press", {29'd0, evt_valid, evt_id, evt_type}, {29'd0, 1'b1, 2'd1, 2'b00});
    step(1);
    check("ovf_release", {29'd0, evt_valid, evt_id, evt_type}, {29'd0, 1'b1, 2'd1, 2'b01});
    step(1);
    check("ovf_done", {31'd0, evt_valid}, 32'd0);
    sb.push_back({2'd1, 2'b01});
    btn_raw[1] = 1'b0;
    wait_level(1, 1'b0, cyc);
    step(8);
    sb.push_back({2'd3, 2'b01});
    btn_raw[3] = 1'b0;
    wait_level(3, 1'b0, cyc);
    step(8);
    check("ovf_sb_empty", sb.size(), 0);
    check("ovf_drop_total", n_drops - d0, 1);

    // Long hold on button 0: 15 ticks after the press tick
    d0 = n_drops;
    sb.push_back({2'd0, 2'b00});
`ifdef BTN_AUTOREPEAT_EN
    for (int r = 0; r < 6; r++) sb.push_back({2'd0, 2'b10});
`endif
    sb.push_back({2'd0, 2'b01});
    btn_raw[0] = 1'b1;
    wait_level(0, 1'b1, cyc);
    step(59);
    btn_raw[0] = 1'b0;
    wait_level(0, 1'b0, cyc);
    step(8);
    check("hold_sb_empty", sb.size(), 0);
    check("hold_no_drop", n_drops - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
